// File: rtl/zimbo_mmio_slave.sv
// Zimbo CPU memory-mapped I/O responder: 8-word window with a TX byte FIFO,
// compare timer with interrupt, control and scratch registers.
module zimbo_mmio_slave #(
  parameter logic [15:0] BASE_ADDR = 16'hFFF8,
  parameter int          FIFO_AW   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addrm,
  input  logic [15:0] wmdata,
  input  logic        memwr_en,
  output logic [15:0] rmdata_io,
  output logic        io_hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int                 DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_MAX = {1'b1, {FIFO_AW{1'b0}}};

  localparam logic [2:0] OFF_TXDATA  = 3'd0;
  localparam logic [2:0] OFF_STATUS  = 3'd1;
  localparam logic [2:0] OFF_TCNT    = 3'd2;
  localparam logic [2:0] OFF_TCMP    = 3'd3;
  localparam logic [2:0] OFF_CTRL    = 3'd4;
  localparam logic [2:0] OFF_SCRATCH = 3'd5;

  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic               overflow_r;
  logic [15:0]        timer_cnt_r;
  logic [15:0]        timer_cmp_r;
  logic               timer_flag_r;
  logic               timer_en_r;
  logic               irq_en_r;
  logic [15:0]        scratch_r;
  logic [15:0]        rmdata_r;
  logic               io_hit_r;

  logic       hit_s;
  logic [2:0] off_s;
  logic       wr_s;
  logic       rd_s;
  logic       full_s;
  logic       empty_s;
  logic       pop_s;
  logic       push_req_s;
  logic       push_s;
  logic       status_wr_s;
  logic       match_s;
  logic [3:0] cnt4_s;
  logic [15:0] status_s;
  logic [15:0] rd_mux_s;

  assign hit_s       = (addrm[15:3] == BASE_ADDR[15:3]);
  assign off_s       = addrm[2:0];
  assign wr_s        = memwr_en & hit_s;
  assign rd_s        = ~memwr_en & hit_s;
  assign full_s      = (count_r == CNT_MAX);
  assign empty_s     = (count_r == {(FIFO_AW+1){1'b0}});
  assign pop_s       = ~empty_s & tx_ready;
  assign push_req_s  = wr_s & (off_s == OFF_TXDATA);
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign push_s      = push_req_s & (~full_s | pop_s);
  assign status_wr_s = wr_s & (off_s == OFF_STATUS);
  assign match_s     = timer_en_r & (timer_cnt_r == timer_cmp_r);
  assign cnt4_s      = 4'(count_r);
  assign status_s    = {4'b0000, cnt4_s, 4'b0000, overflow_r, timer_flag_r, full_s, empty_s};

  assign tx_data   = mem_r[rd_ptr_r];
  assign tx_valid  = ~empty_s;
  assign irq       = timer_flag_r & irq_en_r;
  assign rmdata_io = rmdata_r;
  assign io_hit    = io_hit_r;

  // Register read multiplexer, reflecting state before this edge's updates.
  always_comb begin
    rd_mux_s = 16'h0000;
    case (off_s)
      OFF_TXDATA:  rd_mux_s = 16'h0000;
      OFF_STATUS:  rd_mux_s = status_s;
      OFF_TCNT:    rd_mux_s = timer_cnt_r;
      OFF_TCMP:    rd_mux_s = timer_cmp_r;
      OFF_CTRL:    rd_mux_s = {14'h0000, irq_en_r, timer_en_r};
      OFF_SCRATCH: rd_mux_s = scratch_r;
      default:     rd_mux_s = 16'h0000;
    endcase
  end

  // FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wmdata[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r   <= {FIFO_AW{1'b0}};
      rd_ptr_r   <= {FIFO_AW{1'b0}};
      count_r    <= {(FIFO_AW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (push_req_s && full_s && !pop_s) overflow_r <= 1'b1;
      else if (status_wr_s && wmdata[3]) overflow_r <= 1'b0;
    end
  end

  // Timer, its flag and the CPU-writable control/scratch registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_cnt_r  <= 16'h0000;
      timer_cmp_r  <= 16'hFFFF;
      timer_flag_r <= 1'b0;
      timer_en_r   <= 1'b0;
      irq_en_r     <= 1'b0;
      scratch_r    <= 16'h0000;
    end else begin
      if (wr_s && off_s == OFF_TCNT) timer_cnt_r <= wmdata;
      else if (match_s)              timer_cnt_r <= 16'h0000;
      else if (timer_en_r)           timer_cnt_r <= timer_cnt_r + 16'h0001;

      if (match_s) timer_flag_r <= 1'b1;
      else if (status_wr_s && wmdata[2]) timer_flag_r <= 1'b0;

      if (wr_s && off_s == OFF_TCMP) timer_cmp_r <= wmdata;
      if (wr_s && off_s == OFF_CTRL) begin
        timer_en_r <= wmdata[0];
        irq_en_r   <= wmdata[1];
      end
      if (wr_s && off_s == OFF_SCRATCH) scratch_r <= wmdata;
    end
  end

  // One-cycle registered read response; writes and misses return zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      rmdata_r <= 16'h0000;
      io_hit_r <= 1'b0;
    end else if (rd_s) begin
      rmdata_r <= rd_mux_s;
      io_hit_r <= 1'b1;
    end else begin
      rmdata_r <= 16'h0000;
      io_hit_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zimbo_mmio_slave.sv
// Self-checking bench for zimbo_mmio_slave: directed scenarios then random
// bus traffic, all checked against a queue-based reference model.
module tb_zimbo_mmio_slave;

  logic        clock;
  logic        reset;
  logic [15:0] addrm;
  logic [15:0] wmdata;
  logic        memwr_en;
  logic [15:0] rmdata_io;
  logic        io_hit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic rdy = 1'b0;

  // Reference model state
  logic [7:0]  q[$];
  logic [15:0] m_cnt, m_cmp, m_scr, m_rd;
  logic [1:0]  m_ctrl;
  logic        m_flag, m_ovf, m_hit;

  zimbo_mmio_slave dut (
    .clock(clock), .reset(reset), .addrm(addrm), .wmdata(wmdata),
    .memwr_en(memwr_en), .rmdata_io(rmdata_io), .io_hit(io_hit),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] off);
    logic [3:0] n;
    n = 4'(q.size());
    case (off)
      3'd1:    return {4'h0, n, 4'h0, m_ovf, m_flag, (q.size() == 8), (q.size() == 0)};
      3'd2:    return m_cnt;
      3'd3:    return m_cmp;
      3'd4:    return {14'h0000, m_ctrl};
      3'd5:    return m_scr;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic [15:0] a, input logic [15:0] d,
                            input logic we, input logic r);
    int n;
    logic hit, pop, push, match;
    logic [2:0] off;
    if (rst) begin
      q.delete();
      m_cnt = 16'h0000; m_cmp = 16'hFFFF; m_scr = 16'h0000; m_ctrl = 2'b00;
      m_flag = 1'b0; m_ovf = 1'b0; m_rd = 16'h0000; m_hit = 1'b0;
      return;
    end
    hit   = (a >= 16'hFFF8);
    off   = a[2:0];
    m_hit = hit && !we;
    m_rd  = m_hit ? m_read(off) : 16'h0000;
    n     = q.size();
    pop   = (n > 0) && r;
    push  = hit && we && (off == 3'd0);
    match = m_ctrl[0] && (m_cnt == m_cmp);
    if (hit && we && off == 3'd1) begin
      if (d[2]) m_flag = 1'b0;
      if (d[3]) m_ovf  = 1'b0;
    end
    if (match) m_flag = 1'b1;
    if (push && n == 8 && !pop) m_ovf = 1'b1;
    if (pop) void'(q.pop_front());
    if (push && (n < 8 || pop)) q.push_back(d[7:0]);
    if (hit && we && off == 3'd2) m_cnt = d;
    else if (m_ctrl[0]) m_cnt = match ? 16'h0000 : m_cnt + 16'h0001;
    if (hit && we && off == 3'd3) m_cmp  = d;
    if (hit && we && off == 3'd4) m_ctrl = d[1:0];
    if (hit && we && off == 3'd5) m_scr  = d;
  endtask

  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic we, input logic rst);
    @(negedge clock);
    addrm = a; wmdata = d; memwr_en = we; tx_ready = rdy; reset = rst;
    @(posedge clock);
    model_step(rst, a, d, we, rdy);
    #1;
    chk("rmdata_io", rmdata_io, m_rd);
    chk("io_hit", {15'h0000, io_hit}, {15'h0000, m_hit});
    chk("tx_valid", {15'h0000, tx_valid}, {15'h0000, q.size() != 0});
    if (q.size() != 0) chk("tx_data", {8'h00, tx_data}, {8'h00, q[0]});
    chk("irq", {15'h0000, irq}, {15'h0000, m_flag & m_ctrl[1]});
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    step(a, d, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a);
    step(a, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    int guard;
    logic [15:0] exp_seq [5];
    logic [15:0] a, d;
    reset = 1'b1; addrm = 16'h0000; wmdata = 16'h0000; memwr_en = 1'b0; tx_ready = 1'b0;

    // Reset and default compare value
    step(16'h0000, 16'h0000, 1'b0, 1'b1);
    step(16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("rst_rmdata", rmdata_io, 16'h0000);
    chk("rst_txvalid", {15'h0000, tx_valid}, 16'h0000);
    chk("rst_irq", {15'h0000, irq}, 16'h0000);
    rd(16'hFFFB);
    chk("cmp_reset", rmdata_io, 16'hFFFF);
    chk("cmp_hit", {15'h0000, io_hit}, 16'h0001);

    // Scratch round trip and out-of-window read
    wr(16'hFFFD, 16'hA5C3);
    rd(16'hFFFD);
    chk("scratch", rmdata_io, 16'hA5C3);
    rd(16'h0010);
    chk("miss_hit", {15'h0000, io_hit}, 16'h0000);

    // Fill, overflow, drain in order
    for (int i = 0; i < 8; i++) wr(16'hFFF8, 16'h0011 + 16'(i));
    rd(16'hFFF9);
    chk("status_full", rmdata_io, 16'h0802);
    wr(16'hFFF8, 16'h0019);
    rd(16'hFFF9);
    chk("status_ovf", rmdata_io, 16'h080A);
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain", {8'h00, tx_data}, 16'h0011 + 16'(i));
      idle();
    end
    chk("drained", {15'h0000, tx_valid}, 16'h0000);

    // Push while full with a simultaneous pop
    rdy = 1'b0;
    wr(16'hFFF9, 16'h0008);
    for (int i = 0; i < 8; i++) wr(16'hFFF8, 16'h0021 + 16'(i));
    rdy = 1'b1;
    wr(16'hFFF8, 16'h0055);
    rdy = 1'b0;
    rd(16'hFFF9);
    chk("full_pushpop", rmdata_io, 16'h0802);
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain2", {8'h00, tx_data}, (i == 7) ? 16'h0055 : 16'h0022 + 16'(i));
      idle();
    end
    rdy = 1'b0;

    // Timer compare, irq, clear, and clear coincident with match
    exp_seq[0] = 16'd0; exp_seq[1] = 16'd1; exp_seq[2] = 16'd2; exp_seq[3] = 16'd3; exp_seq[4] = 16'd0;
    wr(16'hFFFB, 16'h0003);
    wr(16'hFFFC, 16'h0003);
    for (int i = 0; i < 5; i++) begin
      rd(16'hFFFA);
      chk("tcnt_seq", rmdata_io, exp_seq[i]);
      if (i == 3) chk("irq_rise", {15'h0000, irq}, 16'h0001);
    end
    wr(16'hFFF9, 16'h0004);
    chk("irq_clear", {15'h0000, irq}, 16'h0000);
    guard = 0;
    while (m_cnt != m_cmp && guard < 10) begin
      idle();
      guard++;
    end
    chk("match_wait", {15'h0000, guard < 10}, 16'h0001);
    wr(16'hFFF9, 16'h0004);
    chk("set_wins", {15'h0000, irq}, 16'h0001);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) wr(16'hFFF8, 16'h0070 + 16'(i));
    step(16'hFFF9, 16'h0000, 1'b0, 1'b1);
    chk("mid_rst_valid", {15'h0000, tx_valid}, 16'h0000);
    rd(16'hFFF9);
    chk("mid_rst_status", rmdata_io, 16'h0001);
    rd(16'hFFFA);
    chk("mid_rst_tcnt", rmdata_io, 16'h0000);
    rd(16'hFFFC);
    chk("mid_rst_ctrl", rmdata_io, 16'h0000);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      a = ($urandom_range(7, 0) != 0) ? 16'hFFF8 + 16'($urandom_range(7, 0)) : 16'($urandom);
      d = ($urandom_range(1, 0) != 0) ? 16'($urandom_range(12, 0)) : 16'($urandom);
      rdy = ($urandom_range(2, 0) == 0);
      step(a, d, ($urandom_range(1, 0) == 0), ($urandom_range(299, 0) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
